// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event queue: event encodings,
// FSM state enum and the event-word builder.
package key_event_pkg;

    localparam int         EV_W       = 8;
    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_REPEAT  = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [2:0] MAX_ROW    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    function automatic logic [EV_W-1:0] mk_event(input logic [1:0] ev_type,
                                                 input logic [4:0] code);
        return {ev_type, 1'b0, code};
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Valid/ready event stream from the key event queue to its consumer.
interface key_event_queue_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] ev_data;
    logic              ev_valid;
    logic              ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/event_fifo.sv
// Circular-buffer event FIFO with extra pointer MSB for full/empty,
// occupancy count and a sticky overflow flag for dropped pushes.
module event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = !empty && pop;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign valid   = !empty;
    assign count   = wr_ptr - rd_ptr;
    // Gate the unreset storage so the head reads zero whenever the FIFO is empty.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns the scanner's held key level into press/repeat/release events
// and buffers them for a valid/ready consumer.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 25_000_000,
    parameter int REP_CYC  = 5_000_000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   key_rdy,
    input  logic [4:0]             key_code,
    key_event_queue_if.master      ev,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int TMR_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] REP_LD  = TMR_W'(REP_CYC - 1);

    state_t            state, state_n;
    logic [4:0]        cur_code, cur_code_n;
    logic [TMR_W-1:0]  tmr, tmr_n;
    logic              hit;
    logic              push;
    logic [EV_W-1:0]   push_data;

    // Invalid rows look exactly like no key at all.
    assign hit = key_rdy && (key_code[4:2] <= MAX_ROW);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cur_code <= '0;
            tmr      <= '0;
        end else begin
            state    <= state_n;
            cur_code <= cur_code_n;
            tmr      <= tmr_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_code_n = cur_code;
        tmr_n      = tmr;
        push       = 1'b0;
        push_data  = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    push       = 1'b1;
                    push_data  = mk_event(EV_PRESS, key_code);
                    cur_code_n = key_code;
                    tmr_n      = HOLD_LD;
                    state_n    = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // A code change releases the old key; the new press follows from IDLE.
                if (!hit || (key_code != cur_code)) begin
                    push      = 1'b1;
                    push_data = mk_event(EV_RELEASE, cur_code);
                    state_n   = IDLE;
                end else if (tmr == '0) begin
                    push      = 1'b1;
                    push_data = mk_event(EV_REPEAT, cur_code);
                    tmr_n     = REP_LD;
                    state_n   = REPEAT;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    event_fifo #(
        .DATA_W (EV_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (ev.ev_ready),
        .rd_data   (ev.ev_data),
        .valid     (ev.ev_valid),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with short hold/repeat times and a 4-entry FIFO.
module tb_key_event_queue;
    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = 10;
    localparam int REP_CYC  = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       key_rdy;
    logic [4:0] key_code;
    logic       overflow;
    logic       ovf_clr;
    logic [$clog2(DEPTH):0] count;

    key_event_queue_if #(.DATA_W(8)) ev_if ();

    key_event_queue #(
        .DEPTH    (DEPTH),
        .HOLD_CYC (HOLD_CYC),
        .REP_CYC  (REP_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_rdy  (key_rdy),
        .key_code (key_code),
        .ev       (ev_if),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .count    (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] ev_q [$];
    int         ev_t [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every entry the consumer takes, stamped with the cycle it was pushed.
    always @(negedge clk) begin
        if (ev_if.ev_valid && ev_if.ev_ready) begin
            ev_q.push_back(ev_if.ev_data);
            ev_t.push_back(cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ev_q.delete();
        ev_t.delete();
    endtask

    task automatic tap(input logic [4:0] code);
        key_rdy  = 1'b1;
        key_code = code;
        tick();
        key_rdy  = 1'b0;
        tick();
    endtask

    initial begin
        rstn     = 1'b0;
        key_rdy  = 1'b0;
        key_code = '0;
        ovf_clr  = 1'b0;
        ev_if.ev_ready = 1'b1;
        tick(2);
        chk("rst_valid", ev_if.ev_valid, 0);
        chk("rst_data", ev_if.ev_data, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        rstn = 1'b1;
        tick(2);

        // Tap
        clear_log();
        key_rdy = 1'b1; key_code = 5'h09;
        tick(3);
        key_rdy = 1'b0;
        tick(3);
        chk("tap_n", ev_q.size(), 2);
        chk("tap_press", ev_q[0], 8'h09);
        chk("tap_release", ev_q[1], 8'h89);
        chk("tap_dt", ev_t[1] - ev_t[0], 3);

        // Hold with auto-repeat
        clear_log();
        key_rdy = 1'b1; key_code = 5'h13;
        tick(20);
        key_rdy = 1'b0;
        tick(3);
        chk("hold_n", ev_q.size(), 5);
        chk("hold_press", ev_q[0], 8'h13);
        chk("hold_rep1", ev_q[1], 8'h53);
        chk("hold_rep2", ev_q[2], 8'h53);
        chk("hold_rep3", ev_q[3], 8'h53);
        chk("hold_rel", ev_q[4], 8'h93);
        chk("hold_t1", ev_t[1] - ev_t[0], 10);
        chk("hold_t2", ev_t[2] - ev_t[0], 14);
        chk("hold_t3", ev_t[3] - ev_t[0], 18);
        chk("hold_t4", ev_t[4] - ev_t[0], 20);

        // Code change without key_rdy dropping
        clear_log();
        key_rdy = 1'b1; key_code = 5'h02;
        tick(2);
        key_code = 5'h07;
        tick(2);
        key_rdy = 1'b0;
        tick(3);
        chk("chg_n", ev_q.size(), 4);
        chk("chg_e0", ev_q[0], 8'h02);
        chk("chg_e1", ev_q[1], 8'h82);
        chk("chg_e2", ev_q[2], 8'h07);
        chk("chg_e3", ev_q[3], 8'h87);

        // Invalid rows 7 and 5
        clear_log();
        key_rdy = 1'b1; key_code = 5'h1C;
        tick(4);
        key_code = 5'h14;
        tick(4);
        key_rdy = 1'b0;
        tick(2);
        chk("inv_n", ev_q.size(), 0);
        chk("inv_count", count, 0);
        chk("inv_valid", ev_if.ev_valid, 0);

        // Overflow with a stalled consumer
        clear_log();
        ev_if.ev_ready = 1'b0;
        tap(5'h01); tap(5'h02); tap(5'h03); tap(5'h04); tap(5'h05);
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", ev_if.ev_data, 8'h01);
        ovf_clr = 1'b1; key_rdy = 1'b1; key_code = 5'h06;
        tick();
        chk("ovf_set_wins", overflow, 1);
        ovf_clr = 1'b0; key_rdy = 1'b0;
        tick();
        ev_if.ev_ready = 1'b1;
        tick(5);
        chk("drain_n", ev_q.size(), 4);
        chk("drain_e0", ev_q[0], 8'h01);
        chk("drain_e1", ev_q[1], 8'h81);
        chk("drain_e2", ev_q[2], 8'h02);
        chk("drain_e3", ev_q[3], 8'h82);
        chk("drain_count", count, 0);
        chk("drain_ovf_held", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Push and pop together on a full FIFO
        clear_log();
        ev_if.ev_ready = 1'b0;
        tap(5'h08); tap(5'h0A);
        chk("full_count", count, 4);
        ev_if.ev_ready = 1'b1; key_rdy = 1'b1; key_code = 5'h0B;
        tick();
        chk("pp_count_a", count, 4);
        chk("pp_ovf_a", overflow, 0);
        key_rdy = 1'b0;
        tick();
        chk("pp_count_b", count, 4);
        chk("pp_ovf_b", overflow, 0);
        tick(6);
        chk("pp_n", ev_q.size(), 6);
        chk("pp_e0", ev_q[0], 8'h08);
        chk("pp_e1", ev_q[1], 8'h88);
        chk("pp_e2", ev_q[2], 8'h0A);
        chk("pp_e3", ev_q[3], 8'h8A);
        chk("pp_e4", ev_q[4], 8'h0B);
        chk("pp_e5", ev_q[5], 8'h8B);

        // Reset asserted while repeating
        clear_log();
        key_rdy = 1'b1; key_code = 5'h11;
        tick(11);
        chk("rep_head_valid", ev_if.ev_valid, 1);
        chk("rep_head_data", ev_if.ev_data, 8'h51);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", ev_if.ev_valid, 0);
        chk("mid_rst_count", count, 0);
        key_rdy = 1'b0;
        tick(2);
        rstn = 1'b1;
        clear_log();
        tick(5);
        chk("no_release_n", ev_q.size(), 0);

        // Leaving reset with a key already held
        rstn = 1'b0;
        key_rdy = 1'b1; key_code = 5'h05;
        ev_if.ev_ready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_hit_valid", ev_if.ev_valid, 1);
        chk("rst_hit_data", ev_if.ev_data, 8'h05);
        key_rdy = 1'b0;
        ev_if.ev_ready = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
